// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory port arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned DEF_MAX_D_STREAK = 32'd4;

    function automatic arb_state_e busy_state(input logic id);
        if (id == REQ_D) begin
            return BUSY_D;
        end else begin
            return BUSY_I;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_valid, i_rdata, d_valid, d_rdata, mem_req, mem_we, mem_byte, mem_addr,
               mem_wdata, stall_if, stall_mem
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_valid, i_rdata, d_valid, d_rdata, mem_req, mem_we, mem_byte, mem_addr,
               mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of consecutive data grants made while fetch waits;
// force_i_o tells the arbiter to hand the next slot to fetch.
module mem_arb_streak_ctr #(
    parameter int unsigned MAX_D_STREAK = 32'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_i,
    input  logic grant_fetch_i,
    input  logic grant_data_i,
    output logic force_i_o
);
    localparam logic [3:0] MAX_C = 4'(MAX_D_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    // Next streak: cleared whenever fetch is idle or served.
    always_comb begin
        streak_d = streak_q;
        if (!i_req_i || grant_fetch_i) begin
            streak_d = 4'd0;
        end else if (grant_data_i && (streak_q != MAX_C)) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_i_o = (streak_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter sharing one memory port between fetch and MEM stage.
// Optional MEM_ARB_PERF_EN adds conflict / forced-fetch counters.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflict_cycles,
    output logic [31:0]         perf_i_forced
`endif
);
    arb_state_e        state_q, state_d;
    logic              grant_s;
    logic              win_id;
    logic              grant_fetch;
    logic              grant_data;
    logic              force_i;

    logic              mem_req_q;
    logic              cmd_we_q;
    logic              cmd_byte_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic              i_valid_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Winner selection; the valid cycle blocks a grant so the finishing
    // requester cannot be re-granted on its still-high request.
    always_comb begin
        state_d = state_q;
        grant_s = 1'b0;
        win_id  = REQ_I;
        case (state_q)
            IDLE: begin
                if (i_valid_q || d_valid_q) begin
                    state_d = IDLE;
                end else if (bus.d_req && (!bus.i_req || !force_i)) begin
                    grant_s = 1'b1;
                    win_id  = REQ_D;
                    state_d = busy_state(REQ_D);
                end else if (bus.i_req) begin
                    grant_s = 1'b1;
                    win_id  = REQ_I;
                    state_d = busy_state(REQ_I);
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_data  = grant_s && (win_id == REQ_D);
    assign grant_fetch = grant_s && (win_id == REQ_I);

    // State, command capture and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_byte_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_data) begin
                cmd_addr_q  <= bus.d_addr;
                cmd_we_q    <= bus.d_we;
                cmd_byte_q  <= bus.d_byte;
                cmd_wdata_q <= bus.d_wdata;
            end else if (grant_fetch) begin
                cmd_addr_q  <= bus.i_addr;
                cmd_we_q    <= 1'b0;
                cmd_byte_q  <= 1'b0;
                cmd_wdata_q <= '0;
            end
            mem_req_q <= (state_d != IDLE);
            i_valid_q <= (state_q == BUSY_I) && bus.mem_ready;
            d_valid_q <= (state_q == BUSY_D) && bus.mem_ready;
            if ((state_q == BUSY_I) && bus.mem_ready) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if ((state_q == BUSY_D) && bus.mem_ready) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    mem_arb_streak_ctr #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_i       (bus.i_req),
        .grant_fetch_i (grant_fetch),
        .grant_data_i  (grant_data),
        .force_i_o     (force_i)
    );

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_we_q;
    assign bus.mem_byte  = cmd_byte_q;
    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_wdata = cmd_wdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.i_req & ~i_valid_q;
    assign bus.stall_mem = bus.d_req & ~d_valid_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conf_q;
    logic [31:0] perf_forced_q;

    // Contention and starvation-guard event counters, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conf_q   <= 32'd0;
            perf_forced_q <= 32'd0;
        end else begin
            if (bus.i_req && bus.d_req) begin
                perf_conf_q <= perf_conf_q + 32'd1;
            end
            if (grant_fetch && bus.d_req && force_i) begin
                perf_forced_q <= perf_forced_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cycles = perf_conf_q;
    assign perf_i_forced        = perf_forced_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two MIPS pipeline requesters: instruction fetch (I) and the MEM-stage load/store path (D).
- Uses a request/grant/valid handshake towards both requesters and a req/ready handshake towards the memory.
- Drives the stall_if and stall_mem pipeline stall inputs.
- Policy is data-priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, number of consecutive D grants allowed while I is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_valid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request
- d_we  in  1  store
- d_byte  in  1  byte access
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  data access complete (1-cycle pulse)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_byte  out  1  byte enable mode
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- stall_if  out  1  hold fetch stage
- stall_mem  out  1  hold MEM stage and everything upstream

Behaviour:
- Reset (async, rst_n=0): state=IDLE, streak=0. All outputs are 0 except i_rdata/d_rdata, which are also 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
  - IDLE: pick a winner in the same cycle the requests are seen.
  - If d_req and (!i_req or streak<MAX_D_STREAK), grant D and go to BUSY_D.
  - Else if i_req, grant I and go to BUSY_I.
  - Else stay in IDLE.
- Grant capture: on grant, latch that requester's address, we, byte and wdata into command registers. mem_req asserts from the next cycle, so grant-to-mem_req latency is 1 cycle.
- BUSY_x:
  - mem_req=1; mem_* are driven from the command registers and held stable until mem_ready.
  - On mem_ready: pulse x_valid for 1 cycle with x_rdata=mem_rdata registered, so valid appears 1 cycle after mem_ready. Return to IDLE.
  - There is no back-to-back grant; minimum access occupancy is 3 cycles (IDLE, BUSY, valid).
- Streak counter:
  - Increments on each D grant while i_req=1, saturating at MAX_D_STREAK.
  - Clears to 0 on any I grant, or on any cycle with i_req=0.
- Stalls:
  - stall_if = i_req & !i_valid.
  - stall_mem = d_req & !d_valid.
  - Both are combinational from registered state and inputs.
- Requester rule: a requester holds req and its fields stable until its valid pulse. Dropping req before completion does not abort an in-flight access; the result is discarded (valid still pulses).
- Stores: d_valid pulses on completion and d_rdata is don't-care (it carries mem_rdata).
- rdata outputs hold their last value between valid pulses.
- Simultaneous i_req and d_req in IDLE with streak<MAX_D_STREAK: D wins.
- Reset mid-access: the access is abandoned, mem_req drops immediately, and no valid pulse is produced.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds 32-bit output counters perf_conflict_cycles and perf_i_forced.
  - perf_conflict_cycles increments on each cycle with i_req&d_req.
  - perf_i_forced increments on each I grant made because streak==MAX_D_STREAK.
  - Both wrap on overflow and reset to 0.
- Not defined: neither the ports nor the logic exist.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the FSM state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - the requester ID constants (REQ_I=1'b0, REQ_D=1'b1);
  - the default MAX_D_STREAK.
- One natural sub-module: mem_arb_streak_ctr, the saturating starvation counter, which produces force_i.

Test Plan:
- Reset, then i_req=1, i_addr=0x400, mem_ready 2 cycles after mem_req, mem_rdata=0x2402000A -> mem_addr=0x400, mem_we=0; i_valid pulses once with i_rdata=0x2402000A; stall_if=1 until then.
- i_req and d_req both asserted in IDLE, d_we=1, d_addr=0x1000, d_wdata=0xDEADBEEF -> D served first (mem_we=1, mem_wdata=0xDEADBEEF); I served afterwards; stall_if remains 1 throughout the D access.
- Starvation: i_req held high, d_req held high continuously, MAX_D_STREAK=4, mem_ready=1 every cycle -> exactly 4 D grants, then 1 I grant, then D resumes; with PERF enabled, perf_i_forced=1.
- Byte load: d_byte=1, d_we=0, d_addr=0x1003 -> mem_byte=1, mem_addr=0x1003; d_valid carries mem_rdata.
- rst_n deasserted in BUSY_D with mem_ready=0 -> mem_req=0 immediately; no d_valid; state=IDLE and streak=0 after release.
- mem_ready held low for 20 cycles -> mem_addr, mem_we and mem_wdata stay stable; stall_mem=1 for the whole wait; exactly one d_valid follows.
